mem_port_arbiter: RTL and testbench

- Shares one single-port unified instruction/data memory between the IF stage (fetch) and the MEM stage (load/store driven by decoder MemRead/MemWrite).
- Sequences each access over a req/ready handshake, returns read data, and generates per-stage stall signals to the hazard logic.
- MEM has fixed priority over IF because it carries the older instruction.
- A watchdog aborts accesses the memory never acknowledges.

---
 rtl/mips_pkg.sv | 17 +
 rtl/bus_watchdog.sv | 29 ++
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Definitions shared by the arbiter, the instruction decoder and the hazard unit.
package mips_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BUSY_IF,
        BUSY_MEM,
        RESP_IF,
        RESP_MEM
    } arbState_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2b;

endpackage

// File: rtl/bus_watchdog.sv
// Counts cycles spent waiting on the memory and flags an access that has run too long.
module bus_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] count;

    // count holds the number of earlier waiting cycles, so expiry lands on the TIMEOUT-th one
    assign expired = enable && (count == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and load/store; MEM has fixed priority.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 64,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              mem_stall,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready,
    output logic              bus_err
);

    arbState_t state;
    logic      dropFlag;
    logic      ifDoneQ;
    logic      busy;
    logic      expired;
    logic      memReq;

    assign busy   = (state == BUSY_IF) || (state == BUSY_MEM);
    assign memReq = mem_rd | mem_wr;

    bus_watchdog #(.TIMEOUT(TIMEOUT)) uWatchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (!busy),
        .enable  (busy),
        .expired (expired)
    );

    // A flush arriving in the response cycle must still cancel the fetch it would complete
    assign if_done   = ifDoneQ & ~if_flush;
    assign mem_stall = memReq & ~mem_done;
    assign if_stall  = (if_req & ~if_done) | mem_stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            dropFlag  <= 1'b0;
            ifDoneQ   <= 1'b0;
            mem_done  <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            m_req     <= 1'b0;
            m_we      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            bus_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (memReq) begin
                        state   <= BUSY_MEM;
                        m_req   <= 1'b1;
                        m_we    <= mem_wr;
                        m_addr  <= mem_addr;
                        m_wdata <= mem_wdata;
                    end else if (if_req && !if_flush) begin
                        state    <= BUSY_IF;
                        m_req    <= 1'b1;
                        m_we     <= 1'b0;
                        m_addr   <= if_addr;
                        m_wdata  <= '0;
                        dropFlag <= 1'b0;
                    end
                end
                BUSY_IF: begin
                    if (m_ready || expired) begin
                        m_req    <= 1'b0;
                        dropFlag <= 1'b0;
                        if (!m_ready) bus_err <= 1'b1;
                        // A flushed fetch still finishes on the bus but is never reported
                        if (dropFlag || if_flush) begin
                            state <= IDLE;
                        end else begin
                            state    <= RESP_IF;
                            ifDoneQ  <= 1'b1;
                            if_rdata <= m_ready ? m_rdata : ERR_DATA;
                        end
                    end else if (if_flush) begin
                        dropFlag <= 1'b1;
                    end
                end
                BUSY_MEM: begin
                    if (m_ready || expired) begin
                        m_req     <= 1'b0;
                        state     <= RESP_MEM;
                        mem_done  <= 1'b1;
                        mem_rdata <= m_ready ? m_rdata : ERR_DATA;
                        if (!m_ready) bus_err <= 1'b1;
                    end
                end
                RESP_IF: begin
                    ifDoneQ <= 1'b0;
                    state   <= IDLE;
                end
                RESP_MEM: begin
                    mem_done <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed checks of the memory port arbiter with hand-computed expectations.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        mem_stall;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ready;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .TIMEOUT  (4),
        .ERR_DATA (32'hDEADBEEF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .if_stall  (if_stall),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .mem_stall (mem_stall),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .m_ready   (m_ready),
        .bus_err   (bus_err)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0;
        m_rdata = '0; m_ready = 1'b0;
        step(); step();
        #1;
        checkVal("rst_m_req", m_req, 0);
        checkVal("rst_m_addr", m_addr, 0);
        checkVal("rst_if_done", if_done, 0);
        checkVal("rst_mem_done", mem_done, 0);
        checkVal("rst_if_stall", if_stall, 0);
        checkVal("rst_bus_err", bus_err, 0);
        reset = 1'b1;

        // Lone fetch, ack on the third BUSY cycle
        step();
        if_req = 1'b1; if_addr = 32'h00400000;
        #1;
        checkVal("f1_stall_idle", if_stall, 1);
        checkVal("f1_req_idle", m_req, 0);
        step(); #1;
        checkVal("f1_m_req", m_req, 1);
        checkVal("f1_m_we", m_we, 0);
        checkVal("f1_m_addr", m_addr, 32'h00400000);
        step(); #1;
        checkVal("f1_req_hold", m_req, 1);
        step();
        m_ready = 1'b1; m_rdata = 32'h8C880004;
        #1;
        checkVal("f1_done_busy", if_done, 0);
        step();
        m_ready = 1'b0; m_rdata = '0;
        #1;
        checkVal("f1_done", if_done, 1);
        checkVal("f1_rdata", if_rdata, 32'h8C880004);
        checkVal("f1_stall_done", if_stall, 0);
        checkVal("f1_req_drop", m_req, 0);
        if_req = 1'b0;
        step(); #1;
        checkVal("f1_done_once", if_done, 0);
        checkVal("f1_rdata_hold", if_rdata, 32'h8C880004);

        // Store and fetch in the same cycle: store first
        if_req = 1'b1; if_addr = 32'h00400004;
        mem_wr = 1'b1; mem_addr = 32'h10010000; mem_wdata = 32'h12345678;
        #1;
        checkVal("s_mem_stall", mem_stall, 1);
        checkVal("s_if_stall", if_stall, 1);
        step(); #1;
        checkVal("s_m_we", m_we, 1);
        checkVal("s_m_addr", m_addr, 32'h10010000);
        checkVal("s_m_wdata", m_wdata, 32'h12345678);
        checkVal("s_if_stall_busy", if_stall, 1);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        #1;
        checkVal("s_mem_done", mem_done, 1);
        checkVal("s_mem_stall_done", mem_stall, 0);
        checkVal("s_if_stall_resp", if_stall, 1);
        mem_wr = 1'b0;
        step(); #1;
        checkVal("s_idle_req", m_req, 0);
        checkVal("s_mem_done_once", mem_done, 0);
        step(); #1;
        checkVal("s_fetch_req", m_req, 1);
        checkVal("s_fetch_we", m_we, 0);
        checkVal("s_fetch_addr", m_addr, 32'h00400004);
        m_ready = 1'b1; m_rdata = 32'h24020005;
        step();
        m_ready = 1'b0;
        #1;
        checkVal("s_fetch_done", if_done, 1);
        checkVal("s_fetch_rdata", if_rdata, 32'h24020005);
        if_req = 1'b0;
        step();

        // Flush in BUSY_IF; ack lands on the 4th BUSY cycle, same cycle as the timeout
        if_req = 1'b1; if_addr = 32'h00400008;
        step();
        if_flush = 1'b1;
        #1;
        checkVal("fl_m_addr", m_addr, 32'h00400008);
        step();
        if_flush = 1'b0; if_addr = 32'h00400040;
        step();
        step();
        m_ready = 1'b1; m_rdata = 32'hBADC0DE0;
        #1;
        checkVal("fl_req_c4", m_req, 1);
        step();
        m_ready = 1'b0;
        #1;
        checkVal("fl_no_done", if_done, 0);
        checkVal("fl_rdata_kept", if_rdata, 32'h24020005);
        checkVal("fl_req_drop", m_req, 0);
        checkVal("fl_no_bus_err", bus_err, 0);
        step(); #1;
        checkVal("fl_regrant_req", m_req, 1);
        checkVal("fl_regrant_addr", m_addr, 32'h00400040);
        m_ready = 1'b1; m_rdata = 32'h08100010;
        step();
        m_ready = 1'b0;
        if_flush = 1'b1;
        #1;
        checkVal("fl_resp_suppress", if_done, 0);
        checkVal("fl_resp_rdata", if_rdata, 32'h08100010);
        if_flush = 1'b0; if_req = 1'b0;
        step();

        // Read and write together: one write transaction
        mem_rd = 1'b1; mem_wr = 1'b1; mem_addr = 32'h10010004; mem_wdata = 32'hCAFEF00D;
        step(); #1;
        checkVal("rw_m_we", m_we, 1);
        checkVal("rw_m_addr", m_addr, 32'h10010004);
        m_ready = 1'b1; m_rdata = 32'h11111111;
        step();
        m_ready = 1'b0;
        #1;
        checkVal("rw_done", mem_done, 1);
        checkVal("rw_rdata", mem_rdata, 32'h11111111);
        mem_rd = 1'b0; mem_wr = 1'b0;
        step(); #1;
        checkVal("rw_done_once", mem_done, 0);
        step(); #1;
        checkVal("rw_single_txn", m_req, 0);

        // Load that is never acknowledged
        mem_rd = 1'b1; mem_addr = 32'h10010008;
        step(); #1;
        checkVal("to_m_req", m_req, 1);
        checkVal("to_m_we", m_we, 0);
        step(); step(); step(); #1;
        checkVal("to_req_c4", m_req, 1);
        checkVal("to_no_err_yet", bus_err, 0);
        step(); #1;
        checkVal("to_req_drop", m_req, 0);
        checkVal("to_done", mem_done, 1);
        checkVal("to_rdata", mem_rdata, 32'hDEADBEEF);
        checkVal("to_bus_err", bus_err, 1);
        mem_rd = 1'b0;
        step();
        m_ready = 1'b1;
        #1;
        checkVal("to_err_sticky", bus_err, 1);
        step(); #1;
        checkVal("stray_ack_mem_done", mem_done, 0);
        checkVal("stray_ack_if_done", if_done, 0);
        checkVal("stray_ack_req", m_req, 0);
        m_ready = 1'b0;

        // Asynchronous reset in the middle of a store
        mem_wr = 1'b1; mem_addr = 32'h1001000C; mem_wdata = 32'h00000001;
        step(); #1;
        checkVal("ar_req_before", m_req, 1);
        #2;
        reset = 1'b0;
        #1;
        checkVal("ar_req_async", m_req, 0);
        checkVal("ar_bus_err_clr", bus_err, 0);
        checkVal("ar_no_done", mem_done, 0);
        step();
        reset = 1'b1;
        #1;
        checkVal("ar_held_idle", m_req, 0);
        step(); #1;
        checkVal("ar_regrant_req", m_req, 1);
        checkVal("ar_regrant_addr", m_addr, 32'h1001000C);
        checkVal("ar_regrant_we", m_we, 1);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        #1;
        checkVal("ar_done", mem_done, 1);
        mem_wr = 1'b0;
        step(); #1;
        checkVal("ar_done_once", mem_done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
